// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Optional brightness control is enabled by defining SEG_SCAN_BRIGHTNESS_EN.
package seg_scan_pkg;

  localparam int unsigned SEG_W = 7;

  typedef enum logic [0:0] {
    ST_ON,
    ST_BLANK
  } state_e;

  // Inactive level of the cathode bus for the chosen pin polarity.
  function automatic logic [SEG_W-1:0] seg_off(int unsigned active_low);
    return (active_low != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  endfunction

  // Inactive level of the anode bus; callers slice down to their digit count (<= 32).
  function automatic logic [31:0] anode_off(int unsigned active_low);
    return (active_low != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Pattern-in / pin-out bundle of the scan driver.
// Brightness exists only when SEG_SCAN_BRIGHTNESS_EN is defined.
interface seg_scan_driver_if
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [SEG_W*NUM_DIGITS-1:0] SegIn;
  logic [NUM_DIGITS-1:0]       DigitEn;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [3:0]                  Brightness;
`endif
  logic [NUM_DIGITS-1:0]       Anode;
  logic [SEG_W-1:0]            Cathode;
  logic                        FrameStart;

`ifdef SEG_SCAN_BRIGHTNESS_EN
  modport master (output SegIn, DigitEn, Brightness, input Anode, Cathode, FrameStart);
  modport slave  (input SegIn, DigitEn, Brightness, output Anode, Cathode, FrameStart);
`else
  modport master (output SegIn, DigitEn, input Anode, Cathode, FrameStart);
  modport slave  (input SegIn, DigitEn, output Anode, Cathode, FrameStart);
`endif

endinterface

// File: rtl/seg_scan_timer.sv
// ON/BLANK phase counter: counts 0..last of the current phase and strobes tc at the end.
// With SEG_SCAN_BRIGHTNESS_EN defined it also exports the count that holds after this edge.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned CNT_W        = 17
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   run,
  input  state_e state,
  output logic   tc
`ifdef SEG_SCAN_BRIGHTNESS_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  localparam logic [CNT_W-1:0] OnLast    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BlankLast = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Terminal detect and next count; held at 0 until scanning has started.
  always_comb begin
    tc    = run && (cnt_q == ((state == ST_ON) ? OnLast : BlankLast));
    cnt_d = (run && !tc) ? cnt_q + CNT_W'(1) : '0;
  end

`ifdef SEG_SCAN_BRIGHTNESS_EN
  assign count = cnt_d;
`endif

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with per-digit blanking gap.
// Define SEG_SCAN_BRIGHTNESS_EN to add a 4-bit duty-cycle brightness control.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned BLANK_CYCLES   = 50,
  parameter int unsigned ACTIVE_LOW_OUT = 1
) (
  input logic              CLK,
  input logic              RSTn,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned CntMax  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax);
  localparam int unsigned IdxW    = $clog2(NUM_DIGITS);
  localparam int unsigned SegAllW = SEG_W * NUM_DIGITS;

  localparam logic [IdxW-1:0]       IdxLast     = IdxW'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SegOff      = seg_off(ACTIVE_LOW_OUT);
  localparam logic [31:0]           AnodeOffAll = anode_off(ACTIVE_LOW_OUT);
  localparam logic [NUM_DIGITS-1:0] AnodeOff    = AnodeOffAll[NUM_DIGITS-1:0];

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    started_q;
  logic [SegAllW-1:0]      seg_sh_q, seg_sh_d;
  logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [SEG_W-1:0]        cathode_q, cathode_d;
  logic                    frame_q, frame_d;
  logic                    tc, advance, lit;
  logic [SEG_W-1:0]        seg_sel;
  logic [NUM_DIGITS-1:0]   onehot;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  localparam int unsigned ProdW = $clog2(REFRESH_DIV) + 4;
  logic [3:0]              bright_sh_q, bright_sh_d;
  logic [CntW-1:0]         count_d;
  logic [ProdW-1:0]        prod;
`endif

  seg_scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CntW)
  ) u_timer (
    .clk   (CLK),
    .rst_n (RSTn),
    .run   (started_q),
    .state (state_q),
    .tc    (tc)
`ifdef SEG_SCAN_BRIGHTNESS_EN
    ,
    .count (count_d)
`endif
  );

  // Next state, digit index, shadow capture and the output values that follow them.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    advance = 1'b0;
    if (started_q && tc) begin
      if (state_q == ST_ON && BLANK_CYCLES != 0) begin
        state_d = ST_BLANK;
      end else begin
        state_d = ST_ON;
        advance = 1'b1;
      end
    end
    if (advance) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end

    // The first edge out of reset counts as entering digit 0.
    frame_d  = !started_q || (advance && idx_q == IdxLast);
    seg_sh_d = frame_d ? bus.SegIn : seg_sh_q;
    en_sh_d  = frame_d ? bus.DigitEn : en_sh_q;

    seg_sel = seg_sh_d[idx_d*SEG_W +: SEG_W];
    onehot  = NUM_DIGITS'(1) << idx_d;
    lit     = (state_d == ST_ON) && en_sh_d[idx_d];
`ifdef SEG_SCAN_BRIGHTNESS_EN
    bright_sh_d = frame_d ? bus.Brightness : bright_sh_q;
    prod        = ProdW'(REFRESH_DIV) * ProdW'(bright_sh_d);
    lit         = lit && (ProdW'(count_d) < (prod >> 4));
`endif
    anode_d   = lit ? (onehot ^ AnodeOff) : AnodeOff;
    cathode_d = lit ? (seg_sel ^ SegOff) : SegOff;
  end

  // State, shadow and output registers; reset forces pins inactive without a clock.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_ON;
      idx_q       <= '0;
      started_q   <= 1'b0;
      seg_sh_q    <= '0;
      en_sh_q     <= '0;
      anode_q     <= AnodeOff;
      cathode_q   <= SegOff;
      frame_q     <= 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      bright_sh_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      started_q   <= 1'b1;
      seg_sh_q    <= seg_sh_d;
      en_sh_q     <= en_sh_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
      frame_q     <= frame_d;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      bright_sh_q <= bright_sh_d;
`endif
    end
  end

  assign bus.Anode      = anode_q;
  assign bus.Cathode    = cathode_q;
  assign bus.FrameStart = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: scoreboard of expected pin states per clock.
// dut_a uses a 2-cycle blanking gap; dut_b uses none. SEG_SCAN_BRIGHTNESS_EN is honoured.
module tb_seg_scan_driver;

  localparam int unsigned NA = 4;
  localparam int unsigned RA = 4;
  localparam int unsigned BA = 2;
  localparam int unsigned SlotA = RA + BA;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  localparam int unsigned RB   = 16;
  localparam int unsigned LitA = (RA * 15) >> 4;
  localparam int unsigned LitB = (RB * 8) >> 4;
`else
  localparam int unsigned RB   = 4;
  localparam int unsigned LitA = RA;
  localparam int unsigned LitB = RB;
`endif

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] ca;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  seg_scan_driver_if #(.NUM_DIGITS(NA)) bus_a ();
  seg_scan_driver_if #(.NUM_DIGITS(NA)) bus_b ();

  seg_scan_driver #(
    .NUM_DIGITS     (NA),
    .REFRESH_DIV    (RA),
    .BLANK_CYCLES   (BA),
    .ACTIVE_LOW_OUT (1)
  ) dut_a (
    .CLK  (clk),
    .RSTn (rst_a),
    .bus  (bus_a)
  );

  seg_scan_driver #(
    .NUM_DIGITS     (NA),
    .REFRESH_DIV    (RB),
    .BLANK_CYCLES   (0),
    .ACTIVE_LOW_OUT (1)
  ) dut_b (
    .CLK  (clk),
    .RSTn (rst_b),
    .bus  (bus_b)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_a(int c, logic [27:0] seg, logic [3:0] en);
    exp_t e;
    int s = c / SlotA;
    int ph = c % SlotA;
    logic [3:0] oh = 4'b0001 << s;
    logic on = (ph < LitA) && en[s];
    e.an = on ? ~oh : 4'hF;
    e.ca = on ? ~seg[s*7 +: 7] : 7'h7F;
    e.fs = (c == 0);
    return e;
  endfunction

  function automatic exp_t model_b(int c, logic [27:0] seg, logic [3:0] en);
    exp_t e;
    int s = c / RB;
    int ph = c % RB;
    logic [3:0] oh = 4'b0001 << s;
    logic on = (ph < LitB) && en[s];
    e.an = on ? ~oh : 4'hF;
    e.ca = on ? ~seg[s*7 +: 7] : 7'h7F;
    e.fs = (c == 0);
    return e;
  endfunction

  task automatic check(string tag, logic [6:0] obs, logic [6:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, want);
    end
  endtask

  task automatic push_a(int n, logic [27:0] seg, logic [3:0] en);
    for (int c = 0; c < n; c++) sb_q.push_back(model_a(c, seg, en));
  endtask

  task automatic push_b(int n, logic [27:0] seg, logic [3:0] en);
    for (int c = 0; c < n; c++) sb_q.push_back(model_b(c, seg, en));
  endtask

  // One clock: sample just after the edge and compare against the oldest expectation.
  task automatic tick(bit sel);
    exp_t want;
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    assert (sb_q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty cyc=%0d observed=0 expected>0", cyc);
    end
    if (sb_q.size() != 0) begin
      want = sb_q.pop_front();
      if (sel) begin
        check("b_anode", {3'b0, bus_b.Anode}, {3'b0, want.an});
        check("b_cathode", bus_b.Cathode, want.ca);
        check("b_framestart", {6'b0, bus_b.FrameStart}, {6'b0, want.fs});
      end else begin
        check("a_anode", {3'b0, bus_a.Anode}, {3'b0, want.an});
        check("a_cathode", bus_a.Cathode, want.ca);
        check("a_framestart", {6'b0, bus_a.FrameStart}, {6'b0, want.fs});
      end
    end
  endtask

  task automatic check_idle(string tag);
    check({tag, "_anode"}, {3'b0, bus_a.Anode}, 7'h0F);
    check({tag, "_cathode"}, bus_a.Cathode, 7'h7F);
    check({tag, "_framestart"}, {6'b0, bus_a.FrameStart}, 7'h00);
  endtask

  initial begin
    logic [27:0] seg;
    logic [3:0]  en;
    rst_a = 1'b1;
    rst_b = 1'b1;
    seg   = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    en    = 4'hF;
    bus_a.SegIn   = seg;
    bus_a.DigitEn = en;
    bus_b.SegIn   = seg;
    bus_b.DigitEn = en;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    bus_a.Brightness = 4'd15;
    bus_b.Brightness = 4'd8;
`endif
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");

    // Frame 1 straight out of reset, then frame 2 with a mid-frame input change.
    rst_a = 1'b1;
    push_a(NA * SlotA, seg, en);
    repeat (NA * SlotA) tick(1'b0);
    push_a(NA * SlotA, seg, en);
    repeat (2 * SlotA + 2) tick(1'b0);
    bus_a.SegIn[6:0] = 7'h06;
    bus_a.DigitEn    = 4'b1011;
    repeat (NA * SlotA - (2 * SlotA + 2)) tick(1'b0);

    // Frame 3 shows the new digit 0 pattern and a dark slot 2.
    seg = bus_a.SegIn;
    en  = bus_a.DigitEn;
    push_a(NA * SlotA, seg, en);
    repeat (NA * SlotA) tick(1'b0);

    // Reset while digit 1 is lit: pins go idle between clock edges.
    push_a(SlotA + 2, seg, en);
    repeat (SlotA + 2) tick(1'b0);
    #2;
    rst_a = 1'b0;
    #1;
    check_idle("async_rst");
    @(posedge clk);
    #1;
    check_idle("rst_hold");
    rst_a = 1'b1;
    push_a(NA * SlotA, seg, en);
    repeat (NA * SlotA) tick(1'b0);

    // No blanking gap.
    rst_b = 1'b1;
    push_b(2 * NA * RB, {7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'hF);
    repeat (NA * RB) tick(1'b1);
    sb_q.delete();
    push_b(NA * RB, {7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'hF);
    repeat (NA * RB) tick(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
